maquina_estados: RTL

Main control state machine for the 4-in/4-out FIFO switch. It sequences the switch through reset, threshold configuration, idle and active operation. It distributes the registered almost-full/almost-empty thresholds (`alto`/`bajo`) to all eight FIFOs. It detects overflow on any FIFO and reports it. It sits beside the arbiter and consumes the `empty_fifos` vector built in the top-level interconnect.

---
 rtl/maquina_estados.sv | 133 +++++++++++++
 1 files changed

// File: rtl/maquina_estados.sv
// Main control FSM for the 4x4 FIFO switch: reset, threshold configuration, idle/active
// sequencing and overflow capture. Define MAQ_ERROR_RECOVER_EN to allow ERROR->INIT on init.
module maquina_estados #(
   parameter int FIFO_DEPTH = 8,
   parameter int THR_WIDTH  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [THR_WIDTH-1:0] umbral_alto_in,
   input  logic [THR_WIDTH-1:0] umbral_bajo_in,
   input  logic [7:0]           empty_fifos,
   input  logic [7:0]           full_fifos,
   input  logic [7:0]           push_fifos,
   output logic [THR_WIDTH-1:0] alto,
   output logic [THR_WIDTH-1:0] bajo,
   output logic [4:0]           state,
   output logic                 idle_out,
   output logic                 error_out,
   output logic [7:0]           error_fifo
);

   typedef enum logic [4:0] {
      ST_RESET  = 5'b00001,
      ST_INIT   = 5'b00010,
      ST_IDLE   = 5'b00100,
      ST_ACTIVE = 5'b01000,
      ST_ERROR  = 5'b10000
   } state_t;

   localparam logic [THR_WIDTH-1:0] MAX_THR = THR_WIDTH'(FIFO_DEPTH - 1);

   state_t               state_q, state_d;
   logic [THR_WIDTH-1:0] alto_q, alto_d;
   logic [THR_WIDTH-1:0] bajo_q, bajo_d;
   logic [7:0]           error_fifo_q, error_fifo_d;

   logic [7:0] ovf_vec;
   logic       ovf;
   logic       cfg_ok;
   logic       all_empty;

   assign ovf_vec   = push_fifos & full_fifos;
   assign ovf       = |ovf_vec;
   assign cfg_ok    = (umbral_bajo_in < umbral_alto_in) && (umbral_alto_in <= MAX_THR);
   assign all_empty = &empty_fifos;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_RESET;
         alto_q       <= '0;
         bajo_q       <= '0;
         error_fifo_q <= '0;
      end else begin
         state_q      <= state_d;
         alto_q       <= alto_d;
         bajo_q       <= bajo_d;
         error_fifo_q <= error_fifo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      alto_d       = alto_q;
      bajo_d       = bajo_q;
      error_fifo_d = error_fifo_q;

      unique case (state_q)
         ST_RESET: begin
            // FIFOs are still held in reset here, so overflow is not meaningful yet.
            state_d = ST_INIT;
         end

         ST_INIT: begin
            if (ovf) begin
               state_d      = ST_ERROR;
               error_fifo_d = ovf_vec;
            end else if (init) begin
               if (cfg_ok) begin
                  alto_d = umbral_alto_in;
                  bajo_d = umbral_bajo_in;
               end
            end else if (bajo_q < alto_q) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (ovf) begin
               state_d      = ST_ERROR;
               error_fifo_d = ovf_vec;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (!all_empty) begin
               state_d = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (ovf) begin
               state_d      = ST_ERROR;
               error_fifo_d = ovf_vec;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (all_empty) begin
               state_d = ST_IDLE;
            end
         end

         ST_ERROR: begin
            // The overflow mask stays frozen while in ERROR, even if new overflows occur.
`ifdef MAQ_ERROR_RECOVER_EN
            if (!ovf && init) begin
               state_d      = ST_INIT;
               error_fifo_d = '0;
            end
`endif
         end

         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   assign state      = state_q;
   assign alto       = alto_q;
   assign bajo       = bajo_q;
   assign error_fifo = error_fifo_q;
   assign idle_out   = (state_q == ST_IDLE);
   assign error_out  = (state_q == ST_ERROR);

endmodule
